// File: rtl/divmmc_pkg.sv
// Shared constants and state type for the DivMMC paging engine.
package divmmc_pkg;

  localparam logic [7:0]  PORT_CTRL   = 8'hE3;
  localparam logic [5:0]  MAPRAM_BANK = 6'd3;

  localparam logic [15:0] TRAP_RST00  = 16'h0000;
  localparam logic [15:0] TRAP_RST08  = 16'h0008;
  localparam logic [15:0] TRAP_RST38  = 16'h0038;
  localparam logic [15:0] TRAP_LOAD   = 16'h04C6;
  localparam logic [15:0] TRAP_SAVE   = 16'h0562;
  localparam logic [15:0] TRAP_NMI    = 16'h0066;

  localparam logic [15:0] INSTANT_LO  = 16'h3D00;
  localparam logic [15:0] INSTANT_HI  = 16'h3DFF;
  localparam logic [15:0] EXIT_LO     = 16'h1FF8;
  localparam logic [15:0] EXIT_HI     = 16'h1FFF;

  typedef enum logic [1:0] {IDLE, PEND_ON, PEND_OFF} state_e;

  // The NMI vector only counts as a trap when the build enables it.
  function automatic logic is_delayed_trap(input logic [15:0] addr, input logic nmi_en);
    return (addr == TRAP_RST00) || (addr == TRAP_RST08) || (addr == TRAP_RST38) ||
           (addr == TRAP_LOAD)  || (addr == TRAP_SAVE)  || (nmi_en && addr == TRAP_NMI);
  endfunction

endpackage

// File: rtl/divmmc_busedge.sv
// Registers the Z80 strobes and emits one-clock opcode-fetch and control-port-write pulses.
module divmmc_busedge
  import divmmc_pkg::*;
(
  input  logic       clk,
  input  logic       mrst,
  input  logic [7:0] a_lo_i,
  input  logic       mreq_n_i,
  input  logic       iorq_n_i,
  input  logic       m1_n_i,
  input  logic       wr_n_i,
  output logic       fetch_o,
  output logic       portwr_o
);

  logic mreq_n_q;
  logic wr_n_q;

  always_ff @(posedge clk) begin
    if (mrst) begin
      mreq_n_q <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      mreq_n_q <= mreq_n_i;
      wr_n_q   <= wr_n_i;
    end
  end

  assign fetch_o  = !m1_n_i && !mreq_n_i && mreq_n_q;
  assign portwr_o = !iorq_n_i && m1_n_i && (a_lo_i == PORT_CTRL) && !wr_n_i && wr_n_q;

endmodule

// File: rtl/divmmc_paging.sv
// DivMMC paging engine: automap state machine, port 0xE3 register and 0x0000-0x3FFF decode.
// Build option DIVMMC_NMI_TRAP_EN adds 0x0066 as a delayed-entry trap.
module divmmc_paging
  import divmmc_pkg::*;
(
  input  logic        clk,
  input  logic        mrst,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic        divmmc_zxromcs,
  output logic        divmmc_eeprom_cs,
  output logic        divmmc_sram_cs,
  output logic        divmmc_sram_write_n,
  output logic [5:0]  divmmc_sram_hiaddr,
  output logic        automap
);

`ifdef DIVMMC_NMI_TRAP_EN
  localparam logic NMI_EN = 1'b1;
`else
  localparam logic NMI_EN = 1'b0;
`endif

  logic       fetch, portwr;
  logic       conmem_q, conmem_d;
  logic       mapram_q, mapram_d;
  logic [5:0] bank_q, bank_d;
  logic       automap_q, automap_d;
  state_e     state_q, state_d;
  logic       unused_rd;

  assign unused_rd = rd_n;

  divmmc_busedge u_busedge (
    .clk      (clk),
    .mrst     (mrst),
    .a_lo_i   (a[7:0]),
    .mreq_n_i (mreq_n),
    .iorq_n_i (iorq_n),
    .m1_n_i   (m1_n),
    .wr_n_i   (wr_n),
    .fetch_o  (fetch),
    .portwr_o (portwr)
  );

  always_ff @(posedge clk) begin
    if (mrst) begin
      conmem_q  <= 1'b0;
      mapram_q  <= 1'b0;
      bank_q    <= 6'd0;
      automap_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      conmem_q  <= conmem_d;
      mapram_q  <= mapram_d;
      bank_q    <= bank_d;
      automap_q <= automap_d;
      state_q   <= state_d;
    end
  end

  // Pending changes land once M1 is over; fetches only occur with m1_n low, so the two never collide.
  always_comb begin
    state_d   = state_q;
    automap_d = automap_q;
    conmem_d  = conmem_q;
    mapram_d  = mapram_q;
    bank_d    = bank_q;
    if (state_q != IDLE && m1_n) begin
      automap_d = (state_q == PEND_ON);
      state_d   = IDLE;
    end
    if (fetch) begin
      if (a >= INSTANT_LO && a <= INSTANT_HI) begin
        automap_d = 1'b1;
      end else if (is_delayed_trap(a, NMI_EN)) begin
        state_d = PEND_ON;
      end else if (a >= EXIT_LO && a <= EXIT_HI) begin
        state_d = PEND_OFF;
      end
    end
    if (portwr) begin
      conmem_d = d[7];
      mapram_d = mapram_q | d[6];
      bank_d   = d[5:0];
    end
  end

  logic mapped_win, lower_half, sram_ro;

  always_comb begin
    mapped_win = (a[15:14] == 2'b00) && (conmem_q || automap_q);
    lower_half = !a[13];
    // The MAPRAM bank stays write-protected wherever it appears unless CONMEM overrides.
    sram_ro    = lower_half || (mapram_q && !conmem_q && bank_q == MAPRAM_BANK);

    divmmc_zxromcs      = !mapped_win;
    divmmc_eeprom_cs    = mapped_win && lower_half && (conmem_q || !mapram_q);
    divmmc_sram_cs      = mapped_win && (!lower_half || (!conmem_q && mapram_q));
    divmmc_sram_hiaddr  = 6'd0;
    if (divmmc_sram_cs) begin
      divmmc_sram_hiaddr = lower_half ? MAPRAM_BANK : bank_q;
    end
    divmmc_sram_write_n = !(divmmc_sram_cs && !sram_ro && !mreq_n && !wr_n);
  end

  assign automap = automap_q;

endmodule

// File: tb/tb_divmmc_paging.sv
// Directed bench for divmmc_paging with a cycle-level reference model and literal spot checks.
module tb_divmmc_paging;

`ifdef DIVMMC_NMI_TRAP_EN
  localparam bit NMI_EN = 1'b1;
`else
  localparam bit NMI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        mrst;
  logic [15:0] a;
  logic [7:0]  d;
  logic        mreq_n, iorq_n, m1_n, rd_n, wr_n;
  logic        zxromcs, eeprom_cs, sram_cs, sram_write_n, automap;
  logic [5:0]  sram_hiaddr;

  int errors = 0;
  int checks = 0;

  divmmc_paging dut (
    .clk                 (clk),
    .mrst                (mrst),
    .a                   (a),
    .d                   (d),
    .mreq_n              (mreq_n),
    .iorq_n              (iorq_n),
    .m1_n                (m1_n),
    .rd_n                (rd_n),
    .wr_n                (wr_n),
    .divmmc_zxromcs      (zxromcs),
    .divmmc_eeprom_cs    (eeprom_cs),
    .divmmc_sram_cs      (sram_cs),
    .divmmc_sram_write_n (sram_write_n),
    .divmmc_sram_hiaddr  (sram_hiaddr),
    .automap             (automap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: paging state tracked as plain variables, updated per clock from the bus rules.
  bit       armed = 1'b0;
  bit       m_conmem, m_mapram, m_automap;
  bit [5:0] m_bank;
  int       m_pend;  // -1 none, 0 pending exit, 1 pending entry
  bit       m_prev_mreq, m_prev_wr;

  always @(posedge clk) begin
    bit ev_fetch, ev_port;
    if (mrst) begin
      armed = 1'b1;
      m_conmem = 0; m_mapram = 0; m_automap = 0; m_bank = 0; m_pend = -1;
      m_prev_mreq = 1; m_prev_wr = 1;
    end else begin
      ev_fetch = !m1_n && !mreq_n && m_prev_mreq;
      ev_port  = !iorq_n && m1_n && a[7:0] == 8'hE3 && !wr_n && m_prev_wr;
      if (m_pend >= 0 && m1_n) begin
        m_automap = (m_pend == 1);
        m_pend = -1;
      end
      if (ev_fetch) begin
        if (a inside {[16'h3D00:16'h3DFF]}) m_automap = 1;
        else if ((a inside {16'h0000, 16'h0008, 16'h0038, 16'h04C6, 16'h0562}) ||
                 (NMI_EN && a == 16'h0066)) m_pend = 1;
        else if (a inside {[16'h1FF8:16'h1FFF]}) m_pend = 0;
      end
      if (ev_port) begin
        m_conmem = d[7];
        m_mapram = m_mapram | d[6];
        m_bank   = d[5:0];
      end
      m_prev_mreq = mreq_n;
      m_prev_wr   = wr_n;
    end
  end

  // Returns {zxromcs, eeprom_cs, sram_cs, write_n, hiaddr[5:0]}.
  function automatic logic [9:0] model_out();
    logic rom, ee, sr, wn, ro;
    logic [5:0] hi;
    rom = 1; ee = 0; sr = 0; wn = 1; ro = 0; hi = 0;
    if (a < 16'h4000 && (m_conmem || m_automap)) begin
      rom = 0;
      if (a < 16'h2000) begin
        if (m_conmem || !m_mapram) ee = 1;
        else begin sr = 1; hi = 6'd3; ro = 1; end
      end else begin
        sr = 1;
        hi = m_bank;
        ro = m_mapram && !m_conmem && m_bank == 6'd3;
      end
      if (sr && !ro && !mreq_n && !wr_n) wn = 0;
    end
    return {rom, ee, sr, wn, hi};
  endfunction

  always @(negedge clk) begin
    logic [9:0] e;
    if (armed) begin
      e = model_out();
      chk("model zxromcs", {7'd0, zxromcs}, {7'd0, e[9]});
      chk("model eeprom_cs", {7'd0, eeprom_cs}, {7'd0, e[8]});
      chk("model sram_cs", {7'd0, sram_cs}, {7'd0, e[7]});
      chk("model sram_write_n", {7'd0, sram_write_n}, {7'd0, e[6]});
      chk("model sram_hiaddr", {2'd0, sram_hiaddr}, {2'd0, e[5:0]});
      chk("model automap", {7'd0, automap}, {7'd0, m_automap});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    step();
    mreq_n = 1; iorq_n = 1; m1_n = 1; rd_n = 1; wr_n = 1;
  endtask

  task automatic do_reset();
    step();
    mrst = 1; mreq_n = 1; iorq_n = 1; m1_n = 1; rd_n = 1; wr_n = 1;
    step();
    step();
    mrst = 0;
  endtask

  task automatic fetch_begin(input logic [15:0] addr);
    step(); a = addr; m1_n = 0;
    step(); mreq_n = 0; rd_n = 0;
    step();
  endtask

  task automatic fetch_end();
    step(); m1_n = 1; mreq_n = 1; rd_n = 1;
  endtask

  task automatic mem_start(input logic [15:0] addr, input logic wr, input logic [7:0] data);
    step(); a = addr; d = data; mreq_n = 0; rd_n = wr; wr_n = !wr;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    step(); a = {8'h12, port}; d = data; iorq_n = 0; wr_n = 0;
    step();
    step(); iorq_n = 1; wr_n = 1;
  endtask

  task automatic full_fetch(input logic [15:0] addr);
    fetch_begin(addr);
    fetch_end();
    step();
  endtask

  initial begin
    mrst = 1; a = 16'h0100; d = 8'h00;
    mreq_n = 1; iorq_n = 1; m1_n = 1; rd_n = 1; wr_n = 1;
    do_reset();

    // Reset state and unmapped read
    mem_start(16'h0100, 0, 8'h00);
    @(negedge clk);
    chk("rst zxromcs", {7'd0, zxromcs}, 8'd1);
    chk("rst eeprom_cs", {7'd0, eeprom_cs}, 8'd0);
    chk("rst sram_cs", {7'd0, sram_cs}, 8'd0);
    chk("rst write_n", {7'd0, sram_write_n}, 8'd1);
    chk("rst hiaddr", {2'd0, sram_hiaddr}, 8'd0);
    chk("rst automap", {7'd0, automap}, 8'd0);
    bus_idle();

    // Delayed entry at 0x0038
    fetch_begin(16'h0038);
    @(negedge clk);
    chk("0038 in M1 automap", {7'd0, automap}, 8'd0);
    chk("0038 in M1 zxromcs", {7'd0, zxromcs}, 8'd1);
    fetch_end();
    @(negedge clk);
    chk("0038 m1 rise automap", {7'd0, automap}, 8'd0);
    @(posedge clk); @(negedge clk);
    chk("0038 after automap", {7'd0, automap}, 8'd1);
    mem_start(16'h0100, 0, 8'h00);
    @(negedge clk);
    chk("0038 read eeprom_cs", {7'd0, eeprom_cs}, 8'd1);
    chk("0038 read zxromcs", {7'd0, zxromcs}, 8'd0);
    bus_idle();

    // Instant entry then delayed exit
    do_reset();
    fetch_begin(16'h3D2F);
    @(negedge clk);
    chk("3D2F instant automap", {7'd0, automap}, 8'd1);
    fetch_end();
    fetch_begin(16'h1FFA);
    @(negedge clk);
    chk("1FFA in M1 automap", {7'd0, automap}, 8'd1);
    fetch_end();
    @(negedge clk);
    chk("1FFA m1 rise automap", {7'd0, automap}, 8'd1);
    @(posedge clk); @(negedge clk);
    chk("1FFA after automap", {7'd0, automap}, 8'd0);
    full_fetch(16'h1FF8);
    full_fetch(16'h0100);

    // MAPRAM: bank 3 read-only at 0x0000, mapram sticky
    do_reset();
    io_write(8'hE3, 8'h42);
    full_fetch(16'h3D00);
    mem_start(16'h0000, 1, 8'hAA);
    @(negedge clk);
    chk("mapram sram_cs", {7'd0, sram_cs}, 8'd1);
    chk("mapram hiaddr", {2'd0, sram_hiaddr}, 8'd3);
    chk("mapram write_n", {7'd0, sram_write_n}, 8'd1);
    chk("mapram eeprom_cs", {7'd0, eeprom_cs}, 8'd0);
    bus_idle();
    io_write(8'hE3, 8'h00);
    mem_start(16'h0000, 0, 8'h00);
    @(negedge clk);
    chk("mapram sticky sram_cs", {7'd0, sram_cs}, 8'd1);
    bus_idle();
    io_write(8'hE3, 8'h03);
    mem_start(16'h2000, 1, 8'h55);
    @(negedge clk);
    chk("bank3 upper write_n", {7'd0, sram_write_n}, 8'd1);
    chk("bank3 upper hiaddr", {2'd0, sram_hiaddr}, 8'd3);
    bus_idle();
    io_write(8'hE3, 8'h04);
    mem_start(16'h2000, 1, 8'h55);
    @(negedge clk);
    chk("bank4 upper write_n", {7'd0, sram_write_n}, 8'd0);
    bus_idle();

    // CONMEM with bank 5
    do_reset();
    io_write(8'hE3, 8'h85);
    step(); a = 16'h2000;
    @(negedge clk);
    chk("85 idle write_n", {7'd0, sram_write_n}, 8'd1);
    chk("85 sram_cs", {7'd0, sram_cs}, 8'd1);
    chk("85 hiaddr", {2'd0, sram_hiaddr}, 8'd5);
    mem_start(16'h2000, 1, 8'h11);
    @(negedge clk);
    chk("85 write write_n", {7'd0, sram_write_n}, 8'd0);
    bus_idle();
    @(negedge clk);
    chk("85 released write_n", {7'd0, sram_write_n}, 8'd1);
    mem_start(16'h0000, 0, 8'h00);
    @(negedge clk);
    chk("85 low eeprom_cs", {7'd0, eeprom_cs}, 8'd1);
    chk("85 automap", {7'd0, automap}, 8'd0);
    bus_idle();
    mem_start(16'h4000, 1, 8'h00);
    @(negedge clk);
    chk("85 4000 zxromcs", {7'd0, zxromcs}, 8'd1);
    chk("85 4000 sram_cs", {7'd0, sram_cs}, 8'd0);
    bus_idle();

    // Pending apply and port write on the same edge
    do_reset();
    fetch_begin(16'h0000);
    step(); m1_n = 1; mreq_n = 1; rd_n = 1; a = 16'h00E3; d = 8'h01; iorq_n = 0; wr_n = 0;
    step();
    step(); iorq_n = 1; wr_n = 1;
    mem_start(16'h2000, 1, 8'h22);
    @(negedge clk);
    chk("simul automap", {7'd0, automap}, 8'd1);
    chk("simul hiaddr", {2'd0, sram_hiaddr}, 8'd1);
    chk("simul write_n", {7'd0, sram_write_n}, 8'd0);
    bus_idle();

    // NMI vector
    do_reset();
    full_fetch(16'h0066);
    @(negedge clk);
    chk("0066 automap", {7'd0, automap}, {7'd0, NMI_EN});

    // Reset during a pending M1
    do_reset();
    fetch_begin(16'h0008);
    step(); mrst = 1;
    step(); mrst = 0; m1_n = 1; mreq_n = 1; rd_n = 1;
    @(posedge clk); @(negedge clk);
    chk("mrst abort automap", {7'd0, automap}, 8'd0);
    step();
    @(negedge clk);
    chk("mrst abort later", {7'd0, automap}, 8'd0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
